// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates a one-hot column drive, debounces a single closed key,
// and reports its position once per press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t        state_q, state_d;
    logic [3:0]    rs_meta_q, rs_meta_d;
    logic [3:0]    rs_q, rs_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] db_q, db_d;
    logic [3:0]    latched_q, latched_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          rs_onehot;
    logic [1:0]    col_next;
    logic [1:0]    row_idx;

    assign rs_onehot = (rs_q != 4'd0) && ((rs_q & (rs_q - 4'd1)) == 4'd0);
    assign col_next  = col_idx_q + 2'd1;

    always_comb begin
        row_idx = 2'd0;
        case (latched_q)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        rs_meta_d   = rows;
        rs_d        = rs_meta_q;
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        latched_d   = latched_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                // Rows are only trusted at the end of the dwell, once the column has settled.
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (rs_onehot) begin
                        latched_d = rs_q;
                        db_d      = '0;
                        state_d   = PRESS_DB;
                    end else begin
                        col_idx_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            PRESS_DB: begin
                if (rs_q == latched_q) begin
                    if (db_q == DB_LAST) begin
                        db_d        = '0;
                        state_d     = HELD;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        key_code_d  = {row_idx, col_idx_q};
                    end else begin
                        db_d = db_q + BW'(1);
                    end
                end else begin
                    db_d      = '0;
                    dwell_d   = '0;
                    col_idx_d = col_next;
                    state_d   = SCAN;
                end
            end
            HELD: begin
                if (rs_q == 4'd0) begin
                    db_d    = '0;
                    state_d = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (rs_q == 4'd0) begin
                    if (db_q == DB_LAST) begin
                        db_d       = '0;
                        dwell_d    = '0;
                        col_idx_d  = col_next;
                        key_held_d = 1'b0;
                        state_d    = SCAN;
                    end else begin
                        db_d = db_q + BW'(1);
                    end
                end else begin
                    db_d    = '0;
                    state_d = HELD;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            rs_meta_q   <= 4'd0;
            rs_q        <= 4'd0;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            db_q        <= '0;
            latched_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_meta_q   <= rs_meta_d;
            rs_q        <= rs_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            latched_q   <= latched_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign cols      = 4'b0001 << col_idx_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8); cyc counts
// rising edges since the last reset release and every expectation is keyed on it.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks_total;
    int checks_passed;
    int cyc;

    logic [3:0] exp_cols;
    logic [3:0] exp_code;
    logic       exp_valid;
    logic       exp_held;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rows  = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic check_all(input string name);
        checks_total++;
        if (cols !== exp_cols)
            $display("[TB] FAIL %s cols k=%0d got %b want %b", name, cyc, cols, exp_cols);
        else checks_passed++;
        checks_total++;
        if (key_valid !== exp_valid)
            $display("[TB] FAIL %s key_valid k=%0d got %b want %b", name, cyc, key_valid, exp_valid);
        else checks_passed++;
        checks_total++;
        if (key_held !== exp_held)
            $display("[TB] FAIL %s key_held k=%0d got %b want %b", name, cyc, key_held, exp_held);
        else checks_passed++;
        checks_total++;
        if (key_code !== exp_code)
            $display("[TB] FAIL %s key_code k=%0d got %b want %b", name, cyc, key_code, exp_code);
        else checks_passed++;
    endtask

    task automatic test_reset();
        do_reset();
        exp_cols = 4'b0001; exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'b0000;
        check_all("reset");
    endtask

    task automatic test_idle_scan();
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            exp_cols  = 4'b0001 << ((cyc / 4) % 4);
            exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'b0000;
            check_all("idle_scan");
            tick();
        end
    endtask

    // Key at row 2 / column 1 is visible from cycle 6, sampled at cycle 7, accepted at cycle 16.
    task automatic test_clean_press();
        do_reset();
        for (int i = 0; i <= 44; i++) begin
            exp_cols  = (cyc < 8) ? (4'b0001 << (cyc / 4)) : 4'b0010;
            exp_valid = (cyc == 16);
            exp_held  = (cyc >= 16);
            exp_code  = (cyc >= 16) ? 4'b1001 : 4'b0000;
            check_all("clean_press");
            if (cyc == 4) rows = 4'b0100;
            tick();
        end
    endtask

    task automatic test_release();
        for (int i = 45; i <= 64; i++) begin
            exp_cols  = (cyc < 56) ? 4'b0010 : (4'b0001 << ((((cyc - 56) / 4) + 2) % 4));
            exp_valid = 1'b0;
            exp_held  = (cyc < 56);
            exp_code  = 4'b1001;
            check_all("release");
            if (cyc == 45) rows = 4'b0000;
            tick();
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i <= 24; i++) begin
            if (cyc < 8)       exp_cols = 4'b0001 << (cyc / 4);
            else if (cyc < 12) exp_cols = 4'b0010;
            else               exp_cols = 4'b0001 << ((((cyc - 12) / 4) + 2) % 4);
            exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'b0000;
            check_all("bounce");
            case (cyc)
                4:  rows = 4'b0100;
                9:  rows = 4'b0000;
                10: rows = 4'b0100;
                12: rows = 4'b0000;
                default: ;
            endcase
            tick();
        end
    endtask

    task automatic test_release_glitch();
        do_reset();
        for (int i = 0; i <= 60; i++) begin
            if (cyc < 8)       exp_cols = 4'b0001 << (cyc / 4);
            else if (cyc < 51) exp_cols = 4'b0010;
            else               exp_cols = 4'b0001 << ((((cyc - 51) / 4) + 2) % 4);
            exp_valid = (cyc == 16);
            exp_held  = (cyc >= 16) && (cyc < 51);
            exp_code  = (cyc >= 16) ? 4'b1001 : 4'b0000;
            check_all("release_glitch");
            case (cyc)
                4:  rows = 4'b0100;
                20: rows = 4'b0000;
                23: rows = 4'b0100;
                30: rows = 4'b0110;
                40: rows = 4'b0000;
                51: rows = 4'b1100;
                default: ;
            endcase
            tick();
        end
        rows = 4'b0000;
    endtask

    task automatic test_reset_override();
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            exp_cols  = (cyc < 8) ? (4'b0001 << (cyc / 4)) : 4'b0010;
            exp_valid = (cyc == 16);
            exp_held  = (cyc >= 16);
            exp_code  = (cyc >= 16) ? 4'b1001 : 4'b0000;
            check_all("pre_reset_hold");
            tick();
            if (i == 3) rows = 4'b0100;
        end
        reset = 1'b1;
        tick();
        exp_cols = 4'b0001; exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'b0000;
        check_all("reset_in_held");

        // Rows still closed: column 0 latches the key and enters press debounce at cycle 4.
        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i <= 8; i++) begin
            exp_cols = 4'b0001; exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'b0000;
            check_all("press_db_frozen");
            tick();
        end
        reset = 1'b1;
        rows  = 4'b0000;
        tick();
        check_all("reset_in_press_db");
        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i <= 20; i++) begin
            exp_cols  = 4'b0001 << ((cyc / 4) % 4);
            exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'b0000;
            check_all("after_reset_scan");
            tick();
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        cyc           = 0;
        reset         = 1'b1;
        rows          = 4'b0000;
        test_reset();
        test_idle_scan();
        test_clean_press();
        test_release();
        test_bounce();
        test_release_glitch();
        test_reset_override();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column is driven while scanning; legal values are 4 or more.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable synchronized samples required to accept a press or a release; legal values are 2 or more.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 rows  input  4  keypad row lines, asynchronous, active-high (1 = key closed in the driven column).
REQ-006 cols  output  4  keypad column drive, one-hot, active-high.
REQ-007 key_code  output  4  accepted key position {row_idx[1:0], col_idx[1:0]}, held stable between presses.
REQ-008 key_valid  output  1  single-cycle pulse marking a newly accepted press.
REQ-009 key_held  output  1  high while an accepted key remains closed.

Function
REQ-010 The block SHALL pass rows through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-011 The FSM SHALL have exactly four states: SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-012 SCAN: cols SHALL rotate 0001->0010->0100->1000->0001, advancing after SCAN_DIV cycles per column; a dwell counter counts 0..SCAN_DIV-1.
REQ-013 SCAN: rs SHALL be evaluated only in the last dwell cycle (counter = SCAN_DIV-1).
- If rs is one-hot: latch rs and the column index, freeze cols, and enter PRESS_DB with db counter = 0.
- If rs is zero or multi-hot: ignore it and advance the column.
REQ-014 PRESS_DB: each cycle rs equals the latched rows, db counter SHALL increment.
REQ-015 PRESS_DB acceptance: on the DEBOUNCE_CYCLES-th consecutive match, the next cycle SHALL have key_valid=1, key_code updated, key_held=1, and state HELD.
REQ-016 PRESS_DB abort: any mismatch (including zero or multi-hot rs) SHALL return to SCAN with the column advanced, dwell counter 0, and no output change.
REQ-017 HELD: cols SHALL stay frozen.
- rs = 0 enters RELEASE_DB with db counter = 0.
- Any other rs value (a second key, a row change) SHALL be ignored; no rollover, no new key_valid.
REQ-018 RELEASE_DB: rs = 0 SHALL increment db counter.
- After DEBOUNCE_CYCLES consecutive zeros: key_held=0 and return to SCAN on the next column, dwell counter 0.
- Any nonzero rs SHALL return to HELD with no key_valid.
REQ-019 key_valid SHALL be high for exactly one cycle per accepted press and never in any other state.
REQ-020 key_code SHALL change only in the key_valid cycle; it retains the last accepted value otherwise.
REQ-021 Counter widths SHALL hold the parameter maxima without wrap; the dwell counter wraps only from SCAN_DIV-1 to 0.
REQ-022 cols SHALL be one-hot in every cycle, including directly after reset.

Reset
REQ-023 reset SHALL produce the following on the next clk edge:
- state SCAN;
- cols = 0001;
- key_code = 0000, key_valid = 0, key_held = 0;
- dwell and db counters = 0;
- synchronizer flops = 0.
REQ-024 reset asserted in any state, mid-debounce or mid-hold, SHALL override all other activity; no key_valid is emitted from the interrupted operation.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-025 Idle scan: release reset with rows=0000 -> cols is 0001 for 4 cycles, then 0010, 0100, 1000, then back to 0001; key_valid stays 0.
REQ-026 Clean press: rows=0100 while cols=0010, held 40 cycles -> exactly one key_valid pulse with key_code=1001, key_held=1, cols frozen at 0010.
REQ-027 Bounce: rows=0100 for 5 cycles, then 0000, then 0100 again -> no key_valid on the aborted attempt; cols resumes rotation from 0100.
REQ-028 Release: after REQ-026, rows=0000 for 8+ cycles -> key_held falls, scanning resumes at cols=0100, key_code stays 1001.
REQ-029 Release glitch and second key: in HELD, rows=0000 for 3 cycles then 0100 -> returns to HELD with no pulse; a second key (rows=0110) -> no pulse; rows=1100 during a SCAN sample -> ignored.
REQ-030 Reset mid-debounce: assert reset 4 cycles into PRESS_DB -> next cycle cols=0001, key_held=0, key_code=0000, no key_valid.
